// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth digit sequencer.
// Digit opcodes, FSM states and the next-set-bit search.
package booth_pkg;

  localparam int A_W_DEF = 8;
  localparam int NDIG = A_W_DEF / 2;
  localparam int IW = 2;

  localparam logic [2:0] OPR_ZERO = 3'b000;
  localparam logic [2:0] OPR_POS1 = 3'b001;
  localparam logic [2:0] OPR_POS2 = 3'b011;
  localparam logic [2:0] OPR_NEG2 = 3'b100;
  localparam logic [2:0] OPR_NEG1 = 3'b101;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  typedef struct packed {
    logic          found;
    logic [IW-1:0] idx;
  } hit_t;

  // Lowest set bit of m at or above position from.
  function automatic hit_t next_set(
    input logic [NDIG-1:0] m,
    input int              from
  );
    hit_t h;
    h = '0;
    for (int j = NDIG - 1; j >= 0; j--) begin
      if (j >= from && m[j]) begin
        h.found = 1'b1;
        h.idx   = IW'(j);
      end
    end
    return h;
  endfunction

  function automatic logic is_zero(input logic [2:0] t);
    return (t == OPR_ZERO) || (t == ~OPR_ZERO);
  endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Extracts one Booth triplet {a[2i+1], a[2i], a[2i-1]} (a[-1] = 0)
// and flags whether it selects a nonzero partial product.
module booth_digit_sel
  import booth_pkg::*;
#(
  parameter int A_W = 8
) (
  input  logic [A_W-1:0] a,
  input  logic [IW-1:0]  idx,
  output logic [2:0]     trip,
  output logic           nz
);

  logic [A_W:0] ext;

  assign ext  = {a, 1'b0};
  assign trip = ext[{idx, 1'b0} +: 3];
  assign nz   = !is_zero(trip);

endmodule

// File: rtl/booth_encod.sv
// Radix-4 Booth digit sequencer: scans a latched multiplier two bits
// per step and streams {opr, extend_one, b_out} over valid/ready.
module booth_encod
  import booth_pkg::*;
#(
  parameter int A_W       = 8,
  parameter int SKIP_ZERO = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [A_W-1:0] a,
  input  logic [A_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2:0]     opr,
  output logic [1:0]     extend_one,
  output logic [A_W-1:0] b_out,
  output logic           out_last,
  output logic           busy
);

  state_t          state;
  logic [A_W-1:0]  a_q;
  logic [A_W-1:0]  src;
  logic [2:0]      trip [NDIG];
  logic [NDIG-1:0] nz;
  logic [NDIG-1:0] emask;
  hit_t            first;
  hit_t            after_first;
  hit_t            nxt;
  hit_t            after_nxt;
  logic [IW-1:0]   fidx;

  // In IDLE the live operand feeds the selectors so the first digit
  // can be registered on the accept edge.
  assign src = (state == IDLE) ? a : a_q;

  for (genvar g = 0; g < NDIG; g++) begin : g_sel
    booth_digit_sel #(
      .A_W (A_W)
    ) u_sel (
      .a    (src),
      .idx  (IW'(g)),
      .trip (trip[g]),
      .nz   (nz[g])
    );
  end

  assign emask    = (SKIP_ZERO != 0) ? nz : '1;
  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    first       = next_set(emask, 0);
    fidx        = first.found ? first.idx : '0;
    after_first = next_set(emask, int'(fidx) + 1);
    nxt         = next_set(emask, int'(extend_one) + 1);
    after_nxt   = next_set(emask, int'(nxt.idx) + 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_q        <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      opr        <= OPR_ZERO;
      extend_one <= '0;
      b_out      <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state      <= EMIT;
            a_q        <= a;
            b_out      <= b;
            busy       <= 1'b1;
            out_valid  <= 1'b1;
            opr        <= trip[fidx];
            extend_one <= fidx;
            out_last   <= !after_first.found;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              opr        <= trip[nxt.idx];
              extend_one <= nxt.idx;
              out_last   <= !after_nxt.found;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_encod.sv
// Directed bench for booth_encod: one instance per SKIP_ZERO setting,
// vector table plus backpressure, reset-abort and back-to-back runs.
module tb_booth_encod;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        skip;
    logic [2:0]  n;
    logic [11:0] oprs;
    logic [7:0]  exts;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       iv0 = 1'b0;
  logic       iv1 = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_ready = 1'b1;
  logic       sel = 1'b0;

  logic       ir0, ir1, ov0, ov1, ol0, ol1, bz0, bz1;
  logic [2:0] op0, op1;
  logic [1:0] ex0, ex1;
  logic [7:0] bo0, bo1;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  booth_encod #(.A_W(8), .SKIP_ZERO(0)) u0 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv0),
    .in_ready   (ir0),
    .a          (a),
    .b          (b),
    .out_valid  (ov0),
    .out_ready  (out_ready),
    .opr        (op0),
    .extend_one (ex0),
    .b_out      (bo0),
    .out_last   (ol0),
    .busy       (bz0)
  );

  booth_encod #(.A_W(8), .SKIP_ZERO(1)) u1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv1),
    .in_ready   (ir1),
    .a          (a),
    .b          (b),
    .out_valid  (ov1),
    .out_ready  (out_ready),
    .opr        (op1),
    .extend_one (ex1),
    .b_out      (bo1),
    .out_last   (ol1),
    .busy       (bz1)
  );

  logic       ir_s, ov_s, ol_s, bz_s;
  logic [2:0] op_s;
  logic [1:0] ex_s;
  logic [7:0] bo_s;

  assign ir_s = sel ? ir1 : ir0;
  assign ov_s = sel ? ov1 : ov0;
  assign ol_s = sel ? ol1 : ol0;
  assign bz_s = sel ? bz1 : bz0;
  assign op_s = sel ? op1 : op0;
  assign ex_s = sel ? ex1 : ex0;
  assign bo_s = sel ? bo1 : bo0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_digit(input string tag, input logic [2:0] eo,
                           input logic [1:0] ee, input logic el,
                           input logic [7:0] eb);
    chk({tag, ".valid"}, 32'(ov_s), 32'd1);
    chk({tag, ".opr"}, 32'(op_s), 32'(eo));
    chk({tag, ".ext"}, 32'(ex_s), 32'(ee));
    chk({tag, ".last"}, 32'(ol_s), 32'(el));
    chk({tag, ".b_out"}, 32'(bo_s), 32'(eb));
    chk({tag, ".busy"}, 32'(bz_s), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".idle_valid"}, 32'(ov_s), 32'd0);
    chk({tag, ".idle_ready"}, 32'(ir_s), 32'd1);
    chk({tag, ".idle_busy"}, 32'(bz_s), 32'd0);
  endtask

  task automatic accept(input logic s, input logic [7:0] av,
                        input logic [7:0] bv);
    @(negedge clk);
    sel = s;
    chk("accept.in_ready", 32'(ir_s), 32'd1);
    a = av;
    b = bv;
    if (s) iv1 = 1'b1;
    else   iv0 = 1'b1;
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  task automatic do_op(input string tag, input vec_t v);
    accept(v.skip, v.a, v.b);
    for (int k = 0; k < int'(v.n); k++) begin
      @(negedge clk);
      chk_digit($sformatf("%s.d%0d", tag, k), v.oprs[3*k +: 3],
                v.exts[2*k +: 2], k == int'(v.n) - 1, v.b);
    end
    @(negedge clk);
    chk_idle(tag);
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{8'h6D, 8'h05, 1'b0, 3'd4,
                {3'b011, 3'b101, 3'b110, 3'b010},
                {2'b11, 2'b10, 2'b01, 2'b00}};
    vecs[1] = '{8'h00, 8'h11, 1'b1, 3'd1, 12'b000, 8'b00};
    vecs[2] = '{8'h40, 8'h22, 1'b1, 3'd1, 12'b010, 8'b11};
    vecs[3] = '{8'h80, 8'h7F, 1'b1, 3'd1, 12'b100, 8'b11};
    vecs[4] = '{8'h6D, 8'hC3, 1'b1, 3'd4,
                {3'b011, 3'b101, 3'b110, 3'b010},
                {2'b11, 2'b10, 2'b01, 2'b00}};
    vecs[5] = '{8'h14, 8'h5A, 1'b1, 3'd2,
                {6'b0, 3'b010, 3'b010},
                {4'b0, 2'b10, 2'b01}};
    vecs[6] = '{8'hFF, 8'h01, 1'b1, 3'd1, 12'b110, 8'b00};
    vecs[7] = '{8'hFF, 8'h80, 1'b0, 3'd4,
                {3'b111, 3'b111, 3'b111, 3'b110},
                {2'b11, 2'b10, 2'b01, 2'b00}};
    vecs[8] = '{8'h03, 8'hFE, 1'b1, 3'd2,
                {6'b0, 3'b001, 3'b110},
                {4'b0, 2'b01, 2'b00}};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.in_ready0", 32'(ir0), 32'd0);
    chk("rst.in_ready1", 32'(ir1), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 32'(ov0), 32'd0);
    chk("rst.opr", 32'(op0), 32'd0);
    chk("rst.ext", 32'(ex0), 32'd0);
    chk("rst.b_out", 32'(bo0), 32'd0);
    chk("rst.last", 32'(ol0), 32'd0);
    chk("rst.busy", 32'(bz0), 32'd0);
    chk("rst.out_valid1", 32'(ov1), 32'd0);
    chk("rst.in_ready0_rel", 32'(ir0), 32'd1);

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i]);

    // backpressure: hold digit 1 for three cycles
    accept(1'b0, 8'h6D, 8'h05);
    @(negedge clk);
    chk_digit("bp.d0", 3'b010, 2'b00, 1'b0, 8'h05);
    @(negedge clk);
    chk_digit("bp.d1", 3'b110, 2'b01, 1'b0, 8'h05);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_digit($sformatf("bp.hold%0d", i), 3'b110, 2'b01, 1'b0, 8'h05);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk_digit("bp.d2", 3'b101, 2'b10, 1'b0, 8'h05);
    @(negedge clk);
    chk_digit("bp.d3", 3'b011, 2'b11, 1'b1, 8'h05);
    @(negedge clk);
    chk_idle("bp");

    // reset pulsed during digit 2 aborts the operation
    accept(1'b0, 8'h6D, 8'h05);
    @(negedge clk);
    chk_digit("ra.d0", 3'b010, 2'b00, 1'b0, 8'h05);
    @(negedge clk);
    chk_digit("ra.d1", 3'b110, 2'b01, 1'b0, 8'h05);
    @(negedge clk);
    chk_digit("ra.d2", 3'b101, 2'b10, 1'b0, 8'h05);
    rst = 1'b1;
    #1;
    chk("ra.in_ready_rst", 32'(ir0), 32'd0);
    @(negedge clk);
    chk("ra.out_valid", 32'(ov0), 32'd0);
    chk("ra.opr", 32'(op0), 32'd0);
    chk("ra.ext", 32'(ex0), 32'd0);
    chk("ra.b_out", 32'(bo0), 32'd0);
    chk("ra.last", 32'(ol0), 32'd0);
    chk("ra.busy", 32'(bz0), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ra.no_more", 32'(ov0), 32'd0);
    begin
      vec_t v;
      v = vecs[0];
      v.b = 8'h33;
      do_op("ra.next", v);
    end

    // back-to-back with in_valid held high
    @(negedge clk);
    sel = 1'b0;
    a = 8'h6D;
    b = 8'h05;
    iv0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_digit("bb.a0", 3'b010, 2'b00, 1'b0, 8'h05);
    a = 8'h14;
    b = 8'hA5;
    @(negedge clk);
    chk_digit("bb.a1", 3'b110, 2'b01, 1'b0, 8'h05);
    @(negedge clk);
    chk_digit("bb.a2", 3'b101, 2'b10, 1'b0, 8'h05);
    @(negedge clk);
    chk_digit("bb.a3", 3'b011, 2'b11, 1'b1, 8'h05);
    @(negedge clk);
    chk("bb.gap_valid", 32'(ov0), 32'd0);
    chk("bb.gap_ready", 32'(ir0), 32'd1);
    @(posedge clk);
    #1;
    iv0 = 1'b0;
    @(negedge clk);
    chk_digit("bb.b0", 3'b000, 2'b00, 1'b0, 8'hA5);
    @(negedge clk);
    chk_digit("bb.b1", 3'b010, 2'b01, 1'b0, 8'hA5);
    @(negedge clk);
    chk_digit("bb.b2", 3'b010, 2'b10, 1'b0, 8'hA5);
    @(negedge clk);
    chk_digit("bb.b3", 3'b000, 2'b11, 1'b1, 8'hA5);
    @(negedge clk);
    chk_idle("bb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/booth_encod.md
# booth_encod

Radix-4 Booth digit sequencer: the producer side of the `booth_recod` digit interface. It accepts a signed multiplier/multiplicand pair and scans the multiplier two bits at a time. For each step it emits one Booth digit `opr`, its shift slot `extend_one` and the multiplicand `b`, over a valid/ready stream. It sits between the operand source and the partial-product recoder, and feeds one digit per cycle when the recoder side does not stall.

## Interface
- `A_W`, 8: multiplier/multiplicand width. Must be even. Only 8 is supported by the downstream 2-bit `extend_one`.
- `SKIP_ZERO`, 0: when 1, do not emit digits that select a zero partial product.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operand pair present.
- `in_ready` output 1: block can accept an operand pair.
- `a` input 8: signed multiplier.
- `b` input 8: signed multiplicand.
- `out_valid` output 1: digit outputs valid.
- `out_ready` input 1: consumer takes the digit.
- `opr` output 3: Booth triplet {a[2i+1], a[2i], a[2i-1]}, with a[-1] = 0.
- `extend_one` output 2: digit index i, which sets the partial-product shift to 2i.
- `b_out` output 8: latched multiplicand, constant for all digits of one operation.
- `out_last` output 1: the current digit is the final digit of the operation.
- `busy` output 1: an operation is in progress.

## Operation
- FSM states: IDLE and EMIT.
- IDLE:
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid && in_ready`: latch `a` and `b`, compute the 4-bit nonzero-digit mask (digit nonzero unless its triplet is 000 or 111), go to EMIT.
- EMIT:
  - `out_valid` = 1; `opr`, `extend_one` and `out_last` describe the current digit.
  - On `out_valid && out_ready`:
    - if `out_last`, go to IDLE;
    - otherwise advance to the next digit.
- Digit order: i = 0, 1, 2, 3 (LSB group first).
- With SKIP_ZERO = 0, all 4 digits are always emitted. `out_last` is set on i = 3.
- With SKIP_ZERO = 1:
  - Only digits whose mask bit is set are emitted, in ascending i. `out_last` is set on the highest set mask bit.
  - If the mask is all zero (a = 0), emit exactly one digit: `opr` = 000, `extend_one` = 00, `out_last` = 1.
- Output stability: while `out_valid && !out_ready`, `opr`, `extend_one`, `b_out` and `out_last` hold constant.
- The `a`, `b` and `in_valid` inputs are ignored while in EMIT.
- Digits are arithmetic-exact: Σ d_i·4^i = a (signed). The digit values are: 000/111 → 0, 001/010 → +1, 011 → +2, 100 → −2, 101/110 → −1.

## Timing
- Reset: state = IDLE. The registered outputs reset to `out_valid` = 0, `out_last` = 0, `opr` = 000, `extend_one` = 00, `b_out` = 0 and `busy` = 0.
- `in_ready` = (state == IDLE) && !rst. It is therefore 0 in any cycle with `rst` high.
- Reset while in EMIT discards the operation: `out_valid` = 0 from the next cycle, and no further digits are emitted.
- Latency: the first digit has `out_valid` high one cycle after the accept edge.
- Throughput with `out_ready` held high: one digit per cycle, so one operation takes 5 cycles (accept plus 4 digits).
- The last handshake returns the block to IDLE. `in_ready` = 1 in the following cycle, with no same-cycle accept on the last handshake.
- `busy` is high from the cycle after accept through the cycle of the last handshake.
- All outputs except `in_ready` are registered.

## Structure
- Package `booth_pkg` holds:
  - the digit opcode constants (OPR_ZERO, OPR_POS1, OPR_POS2, OPR_NEG2, OPR_NEG1);
  - the state enum {IDLE, EMIT};
  - `NDIG` = A_W/2.
- One sub-module, `booth_digit_sel`: combinational. It takes the latched `a` and an index and returns the triplet and the nonzero flag. The top level instantiates it once per digit to build the mask.
- Top level: FSM, digit index counter, and next-set-bit search for SKIP_ZERO.

## Test plan
- a = 8'h6D, b = 8'h05, SKIP_ZERO = 0, `out_ready` = 1 → digits (opr, ext) = (010, 00), (110, 01), (101, 10), (011, 11). `out_last` on the 4th digit. `b_out` = 05 on all four.
- a = 8'h00, SKIP_ZERO = 1 → a single digit (000, 00) with `out_last` = 1. `in_ready` is high again 2 cycles after accept.
- a = 8'h40, SKIP_ZERO = 1 → a single digit (010, 11) with `out_last`. Also a = 8'h80 → a single digit (100, 11).
- Backpressure: a = 8'h6D, `out_ready` held 0 for 3 cycles on digit 1 → (110, 01) held stable, then the sequence resumes without loss or duplication.
- `rst` pulsed high during digit 2 → `out_valid` = 0 the next cycle and all outputs at reset values. The next operand is accepted normally and yields its full digit sequence.
- Back-to-back: `in_valid` held high with two operand pairs → 4 digits, 1 idle-accept cycle, then 4 digits. The second operation's `b_out` differs correctly from the first.
